control_pulse_generator: RTL and testbench

Downstream consumer of the 10-phase timing-pulse sequencer (tp1..tp10, one-hot, one clk each). Accepts one instruction per memory cycle time (MCT) boundary and steps it through 1 or 2 MCTs. For each timing pulse it emits one-cycle register/memory control pulses (WS, RG, WG, RA, WA, RZ, WZ, CI) to the datapath. Sits between the sequence generator and the register/memory datapath of the simulator.

---
 rtl/cpg_pkg.sv | 70 +++++++
 rtl/tp_index_decoder.sv | 22 ++
 rtl/control_pulse_generator.sv | 105 ++++++++++
 tb/tb_control_pulse_generator.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpg_pkg.sv
// Shared constants and decode helpers for the control pulse generator:
// opcode values, ctrl bit positions, MCT counts and the pulse table.
package cpg_pkg;

  localparam int CPG_OPC_W  = 3;
  localparam int CPG_NUM_TP = 10;

  localparam logic [CPG_OPC_W-1:0] OPC_TC   = 3'd0;
  localparam logic [CPG_OPC_W-1:0] OPC_CA   = 3'd1;
  localparam logic [CPG_OPC_W-1:0] OPC_CS   = 3'd2;
  localparam logic [CPG_OPC_W-1:0] OPC_AD   = 3'd3;
  localparam logic [CPG_OPC_W-1:0] OPC_TS   = 3'd4;
  localparam logic [CPG_OPC_W-1:0] OPC_XCH  = 3'd5;
  localparam logic [CPG_OPC_W-1:0] OPC_MASK = 3'd6;
  localparam logic [CPG_OPC_W-1:0] OPC_NOOP = 3'd7;

  localparam int CTRL_WS = 0;
  localparam int CTRL_RG = 1;
  localparam int CTRL_WG = 2;
  localparam int CTRL_RA = 3;
  localparam int CTRL_WA = 4;
  localparam int CTRL_RZ = 5;
  localparam int CTRL_WZ = 6;
  localparam int CTRL_CI = 7;

  typedef enum logic {ST_IDLE, ST_EXEC} state_t;

  function automatic logic [1:0] last_mct(input logic [CPG_OPC_W-1:0] opc);
    return (opc == OPC_TC || opc == OPC_NOOP) ? 2'd1 : 2'd2;
  endfunction

  // tp_idx is zero-based: 0 means tp1, 9 means tp10.
  function automatic logic [7:0] ctrl_decode(input logic [CPG_OPC_W-1:0] opc,
                                             input logic [1:0]           mct,
                                             input logic [3:0]           tp_idx);
    logic [7:0] r;
    r = '0;
    if (mct == 2'd1) begin
      if (tp_idx == 4'd0) r[CTRL_WS] = 1'b1;
      if (tp_idx == 4'd1) r[CTRL_RZ] = 1'b1;
      if (tp_idx == 4'd2) r[CTRL_WZ] = 1'b1;
      if (tp_idx == 4'd3) r[CTRL_RG] = 1'b1;
      if (tp_idx == 4'd7 && opc == OPC_TC) r[CTRL_WZ] = 1'b1;
    end else if (mct == 2'd2) begin
      unique case (opc)
        OPC_CA, OPC_CS, OPC_AD, OPC_MASK: begin
          if (tp_idx == 4'd0) r[CTRL_WS] = 1'b1;
          if (tp_idx == 4'd3) r[CTRL_RG] = 1'b1;
          if (tp_idx == 4'd7) r[CTRL_WA] = 1'b1;
          if (tp_idx == 4'd7 && opc == OPC_CS) r[CTRL_CI] = 1'b1;
        end
        OPC_TS: begin
          if (tp_idx == 4'd0) r[CTRL_WS] = 1'b1;
          if (tp_idx == 4'd5) r[CTRL_RA] = 1'b1;
          if (tp_idx == 4'd6) r[CTRL_WG] = 1'b1;
        end
        OPC_XCH: begin
          if (tp_idx == 4'd0) r[CTRL_WS] = 1'b1;
          if (tp_idx == 4'd3) r[CTRL_RG] = 1'b1;
          if (tp_idx == 4'd5) r[CTRL_RA] = 1'b1;
          if (tp_idx == 4'd6) r[CTRL_WG] = 1'b1;
          if (tp_idx == 4'd7) r[CTRL_WA] = 1'b1;
        end
        default: r = '0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/tp_index_decoder.sv
// Turns the timing-pulse vector into a zero-based index (lowest set bit),
// an any-bit-set flag and an exactly-one-bit-set flag.
module tp_index_decoder #(
  parameter int NUM_TP = 10
) (
  input  logic [NUM_TP-1:0] tp,
  output logic [3:0]        idx,
  output logic              valid,
  output logic              onehot_ok
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    idx       = '0;
    valid     = |tp;
    onehot_ok = ($countones(tp) == 1);
    for (int i = NUM_TP - 1; i >= 0; i--) begin
      if (tp[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/control_pulse_generator.sv
// Steps one instruction through 1 or 2 MCTs and emits registered control
// pulses per timing pulse. Optional macro TP_ONEHOT_CHECK_EN adds a sticky tp fault.
module control_pulse_generator
  import cpg_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int OPC_W  = CPG_OPC_W,
  parameter int NUM_TP = CPG_NUM_TP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_TP-1:0] tp,
  input  logic              instr_valid,
  input  logic [OPC_W-1:0]  instr_opcode,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] s_addr,
  output logic [7:0]        ctrl,
  output logic [1:0]        mct,
  output logic              busy,
  output logic              instr_done,
  output logic              tp_error
);

  state_t           state;
  logic [OPC_W-1:0] opcode;
  logic [3:0]       tp_idx;
  logic             tp_valid;
  logic             onehot_ok;
  logic             tp_last;
  logic             at_last;
  logic             gate_ok;

  tp_index_decoder #(.NUM_TP(NUM_TP)) u_tp_dec (
    .tp        (tp),
    .idx       (tp_idx),
    .valid     (tp_valid),
    .onehot_ok (onehot_ok)
  );

  assign tp_last = tp_valid && (tp_idx == 4'(NUM_TP - 1));
  assign at_last = (mct == last_mct(opcode));

`ifdef TP_ONEHOT_CHECK_EN
  // A fault (now or earlier) blocks acceptance and forces the block idle.
  assign gate_ok = !tp_error && onehot_ok;
`else
  logic unused_onehot_ok;
  assign unused_onehot_ok = onehot_ok;
  assign gate_ok  = 1'b1;
  assign tp_error = 1'b0;
`endif

  assign instr_ready = gate_ok && tp_last && (state == ST_IDLE || at_last);

  // NOTE: non-blocking assignments throughout; a later assignment in the same
  // cycle (a new transfer after retirement) deliberately overrides an earlier one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      opcode     <= '0;
      s_addr     <= '0;
      ctrl       <= '0;
      mct        <= '0;
      busy       <= 1'b0;
      instr_done <= 1'b0;
`ifdef TP_ONEHOT_CHECK_EN
      tp_error   <= 1'b0;
`endif
    end else begin
      ctrl       <= '0;
      instr_done <= 1'b0;
`ifdef TP_ONEHOT_CHECK_EN
      if (!onehot_ok) tp_error <= 1'b1;
`endif
      if (!gate_ok) begin
        state <= ST_IDLE;
        mct   <= '0;
        busy  <= 1'b0;
      end else if (tp_valid) begin
        if (state == ST_EXEC) begin
          ctrl <= ctrl_decode(opcode, mct, tp_idx);
          if (tp_last) begin
            if (!at_last) begin
              mct <= mct + 2'd1;
            end else begin
              instr_done <= 1'b1;
              state      <= ST_IDLE;
              mct        <= '0;
              busy       <= 1'b0;
            end
          end
        end
        if (instr_valid && instr_ready) begin
          opcode <= instr_opcode;
          s_addr <= instr_addr;
          mct    <= 2'd1;
          busy   <= 1'b1;
          state  <= ST_EXEC;
        end
      end
    end
  end

endmodule

// File: tb/tb_control_pulse_generator.sv
// Scoreboard bench: each driven cycle pushes the expected registered outputs,
// which are popped and compared one clock later.
module tb_control_pulse_generator;

  localparam logic [2:0] TC = 3'd0, CA = 3'd1, CS = 3'd2, AD = 3'd3;
  localparam logic [2:0] TS = 3'd4, XCH = 3'd5, MASK = 3'd6, NOOP = 3'd7;
  localparam logic [7:0] P_WS = 8'h01, P_RG = 8'h02, P_WG = 8'h04, P_RA = 8'h08;
  localparam logic [7:0] P_WA = 8'h10, P_RZ = 8'h20, P_WZ = 8'h40, P_CI = 8'h80;

  logic        clk;
  logic        reset;
  logic [9:0]  tp;
  logic        instr_valid;
  logic [2:0]  instr_opcode;
  logic [11:0] instr_addr;
  logic        instr_ready;
  logic [11:0] s_addr;
  logic [7:0]  ctrl;
  logic [1:0]  mct;
  logic        busy;
  logic        instr_done;
  logic        tp_error;

  control_pulse_generator dut (
    .clk          (clk),
    .reset        (reset),
    .tp           (tp),
    .instr_valid  (instr_valid),
    .instr_opcode (instr_opcode),
    .instr_addr   (instr_addr),
    .instr_ready  (instr_ready),
    .s_addr       (s_addr),
    .ctrl         (ctrl),
    .mct          (mct),
    .busy         (busy),
    .instr_done   (instr_done),
    .tp_error     (tp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ctrl;
    logic       done;
    logic [1:0] mct;
    logic       busy;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   phase  = 0;
  logic       m_busy = 1'b0;
  logic [2:0] m_opc  = 3'd0;
  logic [1:0] m_mct  = 2'd0;
  logic       m_err  = 1'b0;

  function automatic logic [1:0] ref_last(input logic [2:0] o);
    return (o == TC || o == NOOP) ? 2'd1 : 2'd2;
  endfunction

  // Expected pulses for timing pulse number tpn (1..10).
  function automatic logic [7:0] ref_ctrl(input logic [2:0] o, input logic [1:0] m, input int tpn);
    logic [7:0] r;
    r = 8'h00;
    if (m == 2'd1) begin
      case (tpn)
        1: r = P_WS;
        2: r = P_RZ;
        3: r = P_WZ;
        4: r = P_RG;
        8: r = (o == TC) ? P_WZ : 8'h00;
        default: r = 8'h00;
      endcase
    end else if (m == 2'd2) begin
      if (o == CA || o == AD || o == MASK || o == CS) begin
        if (tpn == 1) r = P_WS;
        if (tpn == 4) r = P_RG;
        if (tpn == 8) r = (o == CS) ? (P_WA | P_CI) : P_WA;
      end else if (o == TS) begin
        if (tpn == 1) r = P_WS;
        if (tpn == 6) r = P_RA;
        if (tpn == 7) r = P_WG;
      end else if (o == XCH) begin
        if (tpn == 1) r = P_WS;
        if (tpn == 4) r = P_RG;
        if (tpn == 6) r = P_RA;
        if (tpn == 7) r = P_WG;
        if (tpn == 8) r = P_WA;
      end
    end
    return r;
  endfunction

  // Called at a falling edge: compare outputs from the previous drive, drive
  // this cycle, model it, push the expectation, check instr_ready.
  task automatic cycle(input logic [9:0] tpv, input logic v, input logic [2:0] o,
                       input logic [11:0] a);
    exp_t e;
    int   k;
    logic bad;
    logic blocked;
    logic exp_ready;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (ctrl !== e.ctrl) begin
        errors++; $display("FAIL ctrl: got %h expected %h at %0t", ctrl, e.ctrl, $time);
      end
      checks++;
      if (instr_done !== e.done) begin
        errors++; $display("FAIL instr_done: got %b expected %b at %0t", instr_done, e.done, $time);
      end
      checks++;
      if (mct !== e.mct) begin
        errors++; $display("FAIL mct: got %0d expected %0d at %0t", mct, e.mct, $time);
      end
      checks++;
      if (busy !== e.busy) begin
        errors++; $display("FAIL busy: got %b expected %b at %0t", busy, e.busy, $time);
      end
      checks++;
      if (tp_error !== e.err) begin
        errors++; $display("FAIL tp_error: got %b expected %b at %0t", tp_error, e.err, $time);
      end
    end
    tp = tpv; instr_valid = v; instr_opcode = o; instr_addr = a;
    k = -1;
    for (int i = 9; i >= 0; i--) if (tpv[i]) k = i;
    bad = ($countones(tpv) != 1);
    e = '0;
    exp_ready = 1'b0;
    if (reset) begin
      m_busy = 1'b0; m_mct = 2'd0; m_err = 1'b0;
    end else begin
`ifdef TP_ONEHOT_CHECK_EN
      blocked = m_err || bad;
`else
      blocked = 1'b0;
`endif
      exp_ready = !blocked && (k == 9) && (!m_busy || m_mct == ref_last(m_opc));
      if (blocked) begin
        m_busy = 1'b0; m_mct = 2'd0;
      end else if (k >= 0) begin
        if (m_busy) begin
          e.ctrl = ref_ctrl(m_opc, m_mct, k + 1);
          if (k == 9) begin
            if (m_mct < ref_last(m_opc)) m_mct = m_mct + 2'd1;
            else begin e.done = 1'b1; m_busy = 1'b0; m_mct = 2'd0; end
          end
        end
        if (exp_ready && v) begin m_busy = 1'b1; m_opc = o; m_mct = 2'd1; end
      end
`ifdef TP_ONEHOT_CHECK_EN
      if (bad) m_err = 1'b1;
`endif
      e.mct = m_mct; e.busy = m_busy; e.err = m_err;
    end
    sb.push_back(e);
    #1;
    if (!reset) begin
      checks++;
      if (instr_ready !== exp_ready) begin
        errors++; $display("FAIL instr_ready: got %b expected %b at %0t", instr_ready, exp_ready, $time);
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic v, input logic [2:0] o, input logic [11:0] a);
    for (int i = 0; i < n; i++) begin
      cycle(10'(1) << phase, v, o, a);
      phase = (phase + 1) % 10;
    end
  endtask

  task automatic align_to(input int p);
    while (phase != p) run(1, 1'b0, TC, 12'o0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    run(n, 1'b0, TC, 12'o0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    align_to(9);
    run(1, 1'b1, XCH, 12'o0321);
    run(15, 1'b0, TC, 12'o0);       // MCT1 plus MCT2 tp1..tp5
    do_reset(3);                    // MCT2 tp6..tp8 suppressed
    checks++;
    if (ctrl !== 8'h00 || mct !== 2'd0 || busy !== 1'b0 || instr_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_xch: got ctrl=%h mct=%0d busy=%b done=%b expected all 0",
               ctrl, mct, busy, instr_done);
    end
    run(12, 1'b0, TC, 12'o0);
  endtask

  task automatic test_ca();
    align_to(9);
    run(1, 1'b1, CA, 12'o1234);
    checks++;
    if (s_addr !== 12'o1234) begin
      errors++; $display("FAIL ca_s_addr: got %o expected %o", s_addr, 12'o1234);
    end
    run(22, 1'b0, TC, 12'o0);
  endtask

  task automatic test_back_to_back();
    align_to(9);
    run(1, 1'b1, TC, 12'o0007);
    run(10, 1'b1, CS, 12'o0100);    // CS taken in TC's tp10
    checks++;
    if (s_addr !== 12'o0100 || busy !== 1'b1 || mct !== 2'd1) begin
      errors++;
      $display("FAIL b2b_accept: got s_addr=%o busy=%b mct=%0d expected 100 1 1", s_addr, busy, mct);
    end
    run(21, 1'b0, TC, 12'o0);
  endtask

  task automatic test_ready();
    align_to(4);
    run(6, 1'b1, NOOP, 12'o0777);   // offered from tp5, accepted only at tp10
    checks++;
    if (s_addr !== 12'o0777 || busy !== 1'b1) begin
      errors++; $display("FAIL ready_accept: got s_addr=%o busy=%b expected 777 1", s_addr, busy);
    end
    run(12, 1'b0, TC, 12'o0);
  endtask

  task automatic test_stall();
    align_to(9);
    run(1, 1'b1, AD, 12'o0042);
    run(3, 1'b0, TC, 12'o0);
    for (int i = 0; i < 7; i++) cycle(10'b0, 1'b0, TC, 12'o0);
    checks++;
    if (mct !== 2'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL stall_hold: got mct=%0d busy=%b expected 1 1", mct, busy);
    end
    run(25, 1'b0, TC, 12'o0);
  endtask

  task automatic test_multihot();
    align_to(9);
    run(1, 1'b1, XCH, 12'o0555);
    cycle(10'b0000000011, 1'b0, TC, 12'o0);
    phase = 1;
`ifdef TP_ONEHOT_CHECK_EN
    checks++;
    if (tp_error !== 1'b1 || busy !== 1'b0 || instr_done !== 1'b0) begin
      errors++;
      $display("FAIL multihot_fault: got err=%b busy=%b done=%b expected 1 0 0", tp_error, busy, instr_done);
    end
`else
    checks++;
    if (ctrl !== P_WS) begin
      errors++; $display("FAIL multihot_ws: got %h expected %h", ctrl, P_WS);
    end
`endif
    run(20, 1'b0, TC, 12'o0);
  endtask

  initial begin
    reset = 1'b1; tp = '0; instr_valid = 1'b0; instr_opcode = '0; instr_addr = '0;
    do_reset(3);
    test_reset();
    test_ca();
    test_back_to_back();
    test_ready();
`ifndef TP_ONEHOT_CHECK_EN
    test_stall();
`endif
    test_multihot();
    run(1, 1'b0, TC, 12'o0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
